// File: rtl/atm_lkp_pkg.sv
// Shared constants and types for the forwarding-table lookup arbiter.
// The tag carries a fixed-width one-hot id so it fits any requester count up to LKP_MAX_REQ.
package atm_lkp_pkg;

   localparam int LKP_ASIZE   = 8;
   localparam int LKP_DSIZE   = 20;
   localparam int LKP_RD_LAT  = 1;
   localparam int LKP_MAX_REQ = 8;

   typedef struct packed {
      logic                   vld;
      logic [LKP_MAX_REQ-1:0] id;
   } lkp_tag_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map the winner back to its real index.
module rr_arb_core #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx
);

   // Modulo-NREQ add done with an explicit subtract so non-power-of-2 NREQ wraps correctly.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
      logic [PW:0] s;
      s = {1'b0, base} + (PW+1)'(k);
      if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
      return s[PW-1:0];
   endfunction

   logic [NREQ-1:0] rot;
   logic [PW-1:0]   rot_sel;
   logic            found;

   always_comb begin
      rot = '0;
      for (int k = 0; k < NREQ; k++) rot[k] = req[wrap_add(ptr, k)];
   end

   always_comb begin
      found   = 1'b0;
      rot_sel = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found   = 1'b1;
            rot_sel = PW'(k);
         end
      end
   end

   always_comb begin
      gnt     = '0;
      gnt_idx = wrap_add(ptr, int'(rot_sel));
      if (found) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/fwd_lkp_arbiter.sv
// Round-robin sharing of the forwarding-table read port between NREQ requesters,
// returning each entry to its requester as a one-hot tagged response.
module fwd_lkp_arbiter
   import atm_lkp_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ASIZE  = LKP_ASIZE,
   parameter int DSIZE  = LKP_DSIZE,
   parameter int RD_LAT = LKP_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*ASIZE-1:0] req_addr,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [DSIZE-1:0]      rsp_data,
   input  logic                  upd_hold,
   output logic                  lut_rden,
   output logic [ASIZE-1:0]      lut_addr,
   input  logic [DSIZE-1:0]      lut_rdata,
   input  logic                  cnt_clr,
   output logic [15:0]           grant_cnt,
   output logic                  busy
);

   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic            grant;

   logic [PW-1:0]    ptr_q,       ptr_d;
   logic             lut_rden_q,  lut_rden_d;
   logic [ASIZE-1:0] lut_addr_q,  lut_addr_d;
   logic [DSIZE-1:0] rsp_data_q,  rsp_data_d;
   logic [15:0]      grant_cnt_q, grant_cnt_d;
   lkp_tag_t         tag_q [RD_LAT+1];
   lkp_tag_t         tag_d [RD_LAT+1];
   logic             unused_tag_bits;

   // upd_hold masks requests before arbitration, so it always beats a same-cycle grant.
   assign arb_req = upd_hold ? '0 : req_valid;

   rr_arb_core #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req     (arb_req),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign grant     = |arb_gnt;
   assign req_ready = arb_gnt;

   // Grant stage (T): pointer, issue registers and tag entry for stage 0.
   always_comb begin
      ptr_d       = ptr_q;
      lut_rden_d  = grant;
      lut_addr_d  = lut_addr_q;
      grant_cnt_d = grant_cnt_q;
      tag_d[0]    = '0;
      if (grant) begin
         ptr_d        = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
         lut_addr_d   = req_addr[int'(arb_idx)*ASIZE +: ASIZE];
         tag_d[0].vld = 1'b1;
         tag_d[0].id  = LKP_MAX_REQ'(arb_gnt);
         grant_cnt_d  = sat_inc16(grant_cnt_q);
      end
      if (cnt_clr) grant_cnt_d = '0;
   end

   // Read stages (T+1 .. T+1+RD_LAT): tag shifts alongside the table access.
   always_comb begin
      for (int k = 1; k <= RD_LAT; k++) tag_d[k] = tag_q[k-1];
      rsp_data_d = tag_q[RD_LAT-1].vld ? lut_rdata : rsp_data_q;
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= RD_LAT; k++) busy = busy | tag_q[k].vld;
   end

   assign rsp_valid       = tag_q[RD_LAT].vld ? tag_q[RD_LAT].id[NREQ-1:0] : '0;
   assign rsp_data        = rsp_data_q;
   assign lut_rden        = lut_rden_q;
   assign lut_addr        = lut_addr_q;
   assign grant_cnt       = grant_cnt_q;
   assign unused_tag_bits = ^tag_q[RD_LAT].id;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         lut_rden_q  <= 1'b0;
         lut_addr_q  <= '0;
         rsp_data_q  <= '0;
         grant_cnt_q <= '0;
         for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         lut_rden_q  <= lut_rden_d;
         lut_addr_q  <= lut_addr_d;
         rsp_data_q  <= rsp_data_d;
         grant_cnt_q <= grant_cnt_d;
         for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= tag_d[k];
      end
   end

endmodule

// File: tb/tb_fwd_lkp_arbiter.sv
// Bench for fwd_lkp_arbiter: directed scenarios plus randomized traffic against
// a queue-based model of grants and responses.
module tb_fwd_lkp_arbiter;

   localparam int NREQ  = 4;
   localparam int ASIZE = 8;
   localparam int DSIZE = 20;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*ASIZE-1:0] req_addr;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [DSIZE-1:0]      rsp_data;
   logic                  upd_hold;
   logic                  lut_rden;
   logic [ASIZE-1:0]      lut_addr;
   logic [DSIZE-1:0]      lut_rdata;
   logic                  cnt_clr;
   logic [15:0]           grant_cnt;
   logic                  busy;

   logic [DSIZE-1:0] mem [256];
   assign lut_rdata = mem[lut_addr];

   fwd_lkp_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .upd_hold  (upd_hold),
      .lut_rden  (lut_rden),
      .lut_addr  (lut_addr),
      .lut_rdata (lut_rdata),
      .cnt_clr   (cnt_clr),
      .grant_cnt (grant_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state
   typedef struct {
      int               due;
      int               id;
      logic [DSIZE-1:0] data;
   } rsp_t;
   rsp_t             q[$];
   int               m_ptr = 0;
   logic             m_rden;
   logic [ASIZE-1:0] m_addr;
   logic [15:0]      m_cnt;
   logic [DSIZE-1:0] m_last;

   function automatic int model_grant();
      if (upd_hold) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] r;
      r = '0;
      if (i >= 0) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [NREQ-1:0] exp_rsp_valid();
      if (q.size() > 0 && q[0].due == cyc) return onehot(q[0].id);
      return '0;
   endfunction

   function automatic logic [DSIZE-1:0] exp_rsp_data();
      if (q.size() > 0 && q[0].due == cyc) return q[0].data;
      return m_last;
   endfunction

   task automatic tick();
      int   g;
      rsp_t r;
      g = model_grant();
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_rden = 1'b0; m_addr = '0; m_cnt = '0; m_last = '0;
         q.delete();
      end else begin
         if (q.size() > 0 && q[0].due == cyc) begin
            m_last = q[0].data;
            void'(q.pop_front());
         end
         m_rden = (g >= 0);
         if (g >= 0) begin
            m_addr = req_addr[g*ASIZE +: ASIZE];
            r.due  = cyc + 2;
            r.id   = g;
            r.data = mem[m_addr];
            q.push_back(r);
            m_ptr  = (g + 1) % NREQ;
         end
         if (cnt_clr) m_cnt = '0;
         else if (g >= 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; upd_hold = 1'b0; cnt_clr = 1'b0; req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      checks++; if (lut_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b want 0", lut_rden); end
      checks++; if (lut_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", lut_addr); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
      checks++; if (rsp_data !== 20'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      checks++; if (grant_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", grant_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      do_reset();
      req_addr[2*ASIZE +: ASIZE] = 8'h3C;
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      #1;
      checks++; if (lut_rden !== 1'b1) begin errors++; $display("FAIL single_rden: got %b want 1", lut_rden); end
      checks++; if (lut_addr !== 8'h3C) begin errors++; $display("FAIL single_addr: got %h want 3c", lut_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      tick();
      #1;
      checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
      checks++; if (rsp_data !== 20'hABCDE) begin errors++; $display("FAIL single_rsp_data: got %h want abcde", rsp_data); end
      checks++; if (lut_rden !== 1'b0) begin errors++; $display("FAIL single_rden_off: got %b want 0", lut_rden); end
      tick();
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_end: got %b want 0000", rsp_valid); end
      checks++; if (rsp_data !== 20'hABCDE) begin errors++; $display("FAIL single_rsp_hold: got %h want abcde", rsp_data); end
      checks++; if (lut_addr !== 8'h3C) begin errors++; $display("FAIL single_addr_hold: got %h want 3c", lut_addr); end
   endtask

   task automatic test_all_four();
      logic [NREQ-1:0] e;
      do_reset();
      for (int i = 0; i < NREQ; i++) req_addr[i*ASIZE +: ASIZE] = 8'(8'h10 * (i + 1));
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         e = onehot(k % 4);
         checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, e); end
         if (k >= 1) begin
            checks++; if (lut_rden !== 1'b1 || lut_addr !== 8'(8'h10 * ((k - 1) % 4 + 1)))
               begin errors++; $display("FAIL rr_issue[%0d]: got rden=%b addr=%h want addr=%h", k, lut_rden, lut_addr, 8'(8'h10 * ((k - 1) % 4 + 1))); end
         end
         if (k >= 2) begin
            e = onehot((k - 2) % 4);
            checks++; if (rsp_valid !== e || rsp_data !== mem[8'(8'h10 * ((k - 2) % 4 + 1))])
               begin errors++; $display("FAIL rr_rsp[%0d]: got %b/%h want %b/%h", k, rsp_valid, rsp_data, e, mem[8'(8'h10 * ((k - 2) % 4 + 1))]); end
         end
         tick();
      end
      req_valid = '0;
      #1;
      checks++; if (grant_cnt !== 16'd8) begin errors++; $display("FAIL rr_cnt: got %0d want 8", grant_cnt); end
   endtask

   task automatic test_wrap();
      do_reset();
      req_addr = 32'h44332211;
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g0: got %b want 1000", req_ready); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_g1: got %b want 0010", req_ready); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g2: got %b want 1000", req_ready); end
      tick();
      req_valid = '0;
   endtask

   task automatic test_upd_hold();
      do_reset();
      req_addr = 32'h8C7B6A59;
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_g0: got %b want 0001", req_ready); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_g1: got %b want 0010", req_ready); end
      tick();
      upd_hold = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_block0: got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0001 || rsp_data !== mem[8'h59]) begin errors++; $display("FAIL hold_rsp0: got %b/%h want 0001/%h", rsp_valid, rsp_data, mem[8'h59]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy0: got %b want 1", busy); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_block1: got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0010 || rsp_data !== mem[8'h6A]) begin errors++; $display("FAIL hold_rsp1: got %b/%h want 0010/%h", rsp_valid, rsp_data, mem[8'h6A]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy1: got %b want 1", busy); end
      tick();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_fall: got %b want 0", busy); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL hold_rsp_end: got %b want 0000", rsp_valid); end
      tick();
      upd_hold = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_resume: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_addr = 32'h000000A5;
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_grant: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_rsp_valid: got %b want 0000", rsp_valid); end
      checks++; if (lut_rden !== 1'b0 || lut_addr !== 8'h00) begin errors++; $display("FAIL rmid_issue: got %b/%h want 0/00", lut_rden, lut_addr); end
      checks++; if (rsp_data !== 20'h0 || busy !== 1'b0 || grant_cnt !== 16'h0)
         begin errors++; $display("FAIL rmid_state: got data=%h busy=%b cnt=%h want 0/0/0", rsp_data, busy, grant_cnt); end
      tick();
      req_valid = 4'b1111;
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_rsp_late: got %b want 0000", rsp_valid); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
   endtask

   task automatic test_grant_cnt();
      do_reset();
      force dut.grant_cnt_q = 16'hFFFE;
      tick();
      release dut.grant_cnt_q;
      m_cnt = 16'hFFFE;
      #1;
      checks++; if (grant_cnt !== 16'hFFFE) begin errors++; $display("FAIL cnt_preload: got %h want fffe", grant_cnt); end
      req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         checks++; if (grant_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat[%0d]: got %h want ffff", k, grant_cnt); end
      end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      #1;
      checks++; if (grant_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_clr_grant: got %h want 0000", grant_cnt); end
      tick();
      #1;
      checks++; if (grant_cnt !== 16'h0001) begin errors++; $display("FAIL cnt_after_clr: got %h want 0001", grant_cnt); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      int               g;
      int               waitc [NREQ];
      logic [NREQ-1:0]  e;
      do_reset();
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
               req_valid[i] = 1'b1;
               req_addr[i*ASIZE +: ASIZE] = 8'($urandom);
            end
         end
         upd_hold = ($urandom_range(7, 0) == 0);
         cnt_clr  = ($urandom_range(15, 0) == 0);
         #1;
         g = model_grant();
         e = onehot(g);
         checks++; if (req_ready !== e) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", n, req_ready, e); end
         checks++; if (lut_rden !== m_rden || lut_addr !== m_addr) begin errors++; $display("FAIL rand_issue@%0d: got %b/%h want %b/%h", n, lut_rden, lut_addr, m_rden, m_addr); end
         checks++; if (rsp_valid !== exp_rsp_valid() || rsp_data !== exp_rsp_data())
            begin errors++; $display("FAIL rand_rsp@%0d: got %b/%h want %b/%h", n, rsp_valid, rsp_data, exp_rsp_valid(), exp_rsp_data()); end
         checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", n, busy, q.size() != 0); end
         checks++; if (grant_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt@%0d: got %h want %h", n, grant_cnt, m_cnt); end
         checks++; if ((req_ready & ~req_valid) !== '0) begin errors++; $display("FAIL rand_ready_no_req@%0d: got ready=%b valid=%b", n, req_ready, req_valid); end
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || req_ready[i]) waitc[i] = 0;
            else if (req_ready != '0) begin
               waitc[i]++;
               checks++; if (waitc[i] > NREQ - 1) begin errors++; $display("FAIL rand_fair@%0d port%0d: got wait=%0d want <=%0d", n, i, waitc[i], NREQ - 1); end
            end
         end
         tick();
         if (g >= 0) req_valid[g] = 1'b0;
      end
      req_valid = '0;
      upd_hold = 1'b0;
      cnt_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; upd_hold = 1'b0; cnt_clr = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 20'($urandom);
      mem[8'h3C] = 20'hABCDE;
      test_reset();
      test_single();
      test_all_four();
      test_wrap();
      test_upd_hold();
      test_reset_mid();
      test_grant_cnt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
